// File: rtl/rib_wbuf_bridge_pkg.sv
// rib_wbuf_bridge_pkg: shared state encoding and defaults for the write-buffered RIB bridge
package rib_wbuf_bridge_pkg;
  localparam int WB_DEPTH_DEF = 4;
  typedef enum logic [1:0] {
    RWB_IDLE,
    RWB_RD_REQ,
    RWB_RD_WAIT,
    RWB_RD_DONE
  } rwb_state_e;
endpackage

// File: rtl/rib_wbuf_bridge_sync_fifo.sv
// sync_fifo: power-of-2 FIFO with registered storage, count output and simultaneous push/pop
module sync_fifo
  import rib_wbuf_bridge_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = WB_DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic [AW:0]   count_o
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;
  assign do_push = push_i && cnt_q != FULL;
  assign do_pop  = pop_i && cnt_q != '0;
  assign cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign dout_o  = mem_q[rp_q];
  assign count_o = cnt_q;
  // Storage needs no reset: the head is only consumed while the count is non-zero.
  always_ff @(posedge clk)
    if (do_push) mem_q[wp_q] <= din_i;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= do_push ? wp_q + AW'(1) : wp_q;
      rp_q  <= do_pop ? rp_q + AW'(1) : rp_q;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/rib_wbuf_bridge.sv
// rib_wbuf_bridge: posts core writes into a FIFO and serialises reads behind them on a gnt/rvalid master port
module rib_wbuf_bridge
  import rib_wbuf_bridge_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WB_DEPTH = WB_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic              hold_o,
  output logic              m_req_o,
  output logic              m_we_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_wdata_o,
  input  logic              m_gnt_i,
  input  logic              m_rvalid_i,
  input  logic [DATA_W-1:0] m_rdata_i,
  output logic              wb_empty_o
);
  localparam int CW = $clog2(WB_DEPTH) + 1;
  rwb_state_e               state_q, state_d;
  logic [ADDR_W-1:0]        raddr_q, raddr_d, fifo_addr;
  logic [DATA_W-1:0]        rdata_q, rdata_d, fifo_data;
  logic [ADDR_W+DATA_W-1:0] fifo_head;
  logic [CW-1:0]            wb_cnt;
  logic                     idle, wb_full, wb_nempty, rd_req, push, pop, drain;
  assign idle      = state_q == RWB_IDLE;
  assign wb_nempty = wb_cnt != '0;
  assign wb_full   = wb_cnt == CW'(WB_DEPTH);
  assign rd_req    = core_req_i && !core_we_i;
  assign drain     = idle && wb_nempty;
  assign push      = idle && core_req_i && core_we_i && !wb_full;
  assign pop       = drain && m_gnt_i;
  assign {fifo_addr, fifo_data} = fifo_head;
  sync_fifo #(.W(ADDR_W + DATA_W), .DEPTH(WB_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   ({core_addr_i, core_wdata_i}),
    .pop_i   (pop),
    .dout_o  (fifo_head),
    .count_o (wb_cnt)
  );
  // Reads leave IDLE only once every posted write has been granted, preserving order.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RWB_IDLE:    state_d = rd_req && !wb_nempty ? RWB_RD_REQ : RWB_IDLE;
      RWB_RD_REQ:  state_d = m_gnt_i ? RWB_RD_WAIT : RWB_RD_REQ;
      RWB_RD_WAIT: state_d = m_rvalid_i ? RWB_RD_DONE : RWB_RD_WAIT;
      RWB_RD_DONE: state_d = RWB_IDLE;
      default:     state_d = RWB_IDLE;
    endcase
  end
  assign raddr_d = idle && state_d == RWB_RD_REQ ? core_addr_i : raddr_q;
  assign rdata_d = state_q == RWB_RD_WAIT && m_rvalid_i ? m_rdata_i : rdata_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= RWB_IDLE;
      raddr_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      rdata_q <= rdata_d;
    end
  assign hold_o       = (idle && core_req_i && (!core_we_i || wb_full)) ||
                        state_q == RWB_RD_REQ || state_q == RWB_RD_WAIT;
  assign m_req_o      = drain || state_q == RWB_RD_REQ;
  assign m_we_o       = drain;
  assign m_addr_o     = drain ? fifo_addr : state_q == RWB_RD_REQ ? raddr_q : '0;
  assign m_wdata_o    = drain ? fifo_data : '0;
  assign core_rdata_o = state_q == RWB_RD_DONE ? rdata_q : '0;
  assign wb_empty_o   = !wb_nempty;
endmodule
